// File: rtl/lcd_dual_timer_display.sv
// lcd_dual_timer_display: HD44780 4-bit write-only character-LCD driver for the chess timer.
// After the power-on init sequence it continuously redraws one LCD row per player clock,
// "Pn HH:MM:SS" with a '*' on the active player's row, or "SET mm MIN" on row 0 in set mode.
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   setTime             1 = set mode (preset display)
//   timeIn[5:0]         preset minutes, binary 0..63
//   activeCh            index of the running player
//   countedTime         24 bits per channel, BCD {H1,H0,M1,M0,S1,S0}; ch0 in bits [23:0]
//   lcd[5:0]            {E, RS, D7, D6, D5, D4}
//   ready               high once init has completed
//   frame_done          one-cycle pulse after the last character of each refresh
module lcd_dual_timer_display #(
  parameter int unsigned TICKS_PER_US = 100,
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned COLS         = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   setTime,
  input  logic [5:0]             timeIn,
  input  logic                   activeCh,
  input  logic [24*NUM_CH-1:0]   countedTime,
  output logic [5:0]             lcd,
  output logic                   ready,
  output logic                   frame_done
);

  localparam int unsigned C_1US   = TICKS_PER_US;
  localparam int unsigned C_50US  = 50 * TICKS_PER_US;
  localparam int unsigned C_200US = 200 * TICKS_PER_US;
  localparam int unsigned C_2MS   = 2000 * TICKS_PER_US;
  localparam int unsigned C_5MS   = 5000 * TICKS_PER_US;
  localparam int unsigned C_40MS  = 40000 * TICKS_PER_US;
  localparam int unsigned TW      = $clog2(C_40MS + 1);
  localparam int unsigned CTW     = 24 * NUM_CH;
  localparam int unsigned COLW    = $clog2(COLS + 1);

  // S_LOAD latches RS/D for the next nibble; S_SETUP/S_EHIGH/S_HOLD are the E strobe phases.
  typedef enum logic [2:0] {S_PWR, S_LOAD, S_SETUP, S_EHIGH, S_HOLD, S_GAP} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tmr_q, tmr_d, gap_q, gap_d, lim;
  logic            tmr_done, adv;
  logic            init_q, init_d;
  logic [3:0]      idx_q, idx_d;
  logic            row_q, row_d;
  logic [COLW-1:0] col_q, col_d;
  logic            lo_q, lo_d;
  logic            snap_set_q, snap_set_d, snap_act_q, snap_act_d;
  logic [5:0]      snap_tin_q, snap_tin_d;
  logic [CTW-1:0]  snap_ct_q, snap_ct_d;
  logic [5:0]      lcd_q, lcd_d;
  logic            ready_q, ready_d, fd_q, fd_d;

  logic [23:0]     row_time;
  logic [31:0]     ci;
  logic [3:0]      tens, units;
  logic [7:0]      ch, cur_byte;
  logic [3:0]      cur_nib;
  logic            cur_rs;
  logic [TW-1:0]   cur_gap;

  function automatic logic [7:0] digit_ch(input logic [3:0] d);
    return (d > 4'd9) ? 8'h3F : (8'h30 + {4'h0, d});
  endfunction

  // Character for the current data column, built from the frame snapshot.
  always_comb begin
    row_time = (NUM_CH > 1 && row_q) ? snap_ct_q[CTW-1 -: 24] : snap_ct_q[23:0];
    ci       = 32'(col_q) - 32'd1;
    tens     = 4'(snap_tin_q / 6'd10);
    units    = 4'(snap_tin_q % 6'd10);
    ch       = 8'h20;
    if (!snap_set_q) begin
      case (ci)
        0:       ch = 8'h50;
        1:       ch = 8'h31 + {7'h0, row_q};
        3:       ch = digit_ch(row_time[23:20]);
        4:       ch = digit_ch(row_time[19:16]);
        5, 8:    ch = 8'h3A;
        6:       ch = digit_ch(row_time[15:12]);
        7:       ch = digit_ch(row_time[11:8]);
        9:       ch = digit_ch(row_time[7:4]);
        10:      ch = digit_ch(row_time[3:0]);
        default: ch = 8'h20;
      endcase
      if (ci == COLS - 1 && (NUM_CH == 1 || snap_act_q == row_q)) ch = 8'h2A;
    end else if (!row_q) begin
      case (ci)
        0:       ch = 8'h53;
        1:       ch = 8'h45;
        2:       ch = 8'h54;
        4:       ch = digit_ch(tens);
        5:       ch = digit_ch(units);
        7:       ch = 8'h4D;
        8:       ch = 8'h49;
        9:       ch = 8'h4E;
        default: ch = 8'h20;
      endcase
    end
  end

  // Nibble to send at the current position and the wait that follows it.
  always_comb begin
    cur_rs   = 1'b0;
    cur_byte = 8'h00;
    cur_nib  = 4'h0;
    cur_gap  = '0;
    if (init_q) begin
      if (idx_q < 4'd4) begin
        cur_nib = (idx_q == 4'd3) ? 4'h2 : 4'h3;
        case (idx_q)
          4'd0:    cur_gap = TW'(C_5MS);
          4'd1:    cur_gap = TW'(C_200US);
          default: cur_gap = TW'(C_50US);
        endcase
      end else begin
        case (idx_q[3:1])
          3'd2:    cur_byte = 8'h28;
          3'd3:    cur_byte = 8'h0C;
          3'd4:    cur_byte = 8'h06;
          default: cur_byte = 8'h01;
        endcase
        cur_nib = idx_q[0] ? cur_byte[3:0] : cur_byte[7:4];
        if (idx_q[0]) cur_gap = (cur_byte == 8'h01) ? TW'(C_2MS) : TW'(C_50US);
      end
    end else begin
      cur_rs   = (col_q != '0);
      cur_byte = (col_q == '0) ? {1'b1, row_q, 6'h00} : ch;
      cur_nib  = lo_q ? cur_byte[3:0] : cur_byte[7:4];
      if (lo_q) cur_gap = TW'(C_50US);
    end
  end

  // Next-state logic: strobe timing, sequence position, snapshots and flags.
  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    init_d     = init_q;
    idx_d      = idx_q;
    row_d      = row_q;
    col_d      = col_q;
    lo_d       = lo_q;
    snap_set_d = snap_set_q;
    snap_act_d = snap_act_q;
    snap_tin_d = snap_tin_q;
    snap_ct_d  = snap_ct_q;
    lcd_d      = {1'b0, lcd_q[4:0]};
    ready_d    = ready_q;
    fd_d       = 1'b0;
    adv        = 1'b0;

    case (state_q)
      S_PWR:   lim = TW'(C_40MS);
      S_GAP:   lim = gap_q;
      default: lim = TW'(C_1US);
    endcase
    tmr_done = (tmr_q == lim - TW'(1));
    tmr_d    = tmr_done ? '0 : tmr_q + TW'(1);

    case (state_q)
      S_PWR:   if (tmr_done) state_d = S_LOAD;
      S_LOAD: begin
        lcd_d[4:0] = {cur_rs, cur_nib};
        tmr_d      = '0;
        state_d    = S_SETUP;
      end
      S_SETUP: if (tmr_done) state_d = S_EHIGH;
      S_EHIGH: if (tmr_done) state_d = S_HOLD;
      S_HOLD: begin
        if (tmr_done) begin
          if (cur_gap == '0) adv = 1'b1;
          else begin
            gap_d   = cur_gap;
            state_d = S_GAP;
          end
        end
      end
      S_GAP:   if (tmr_done) adv = 1'b1;
      default: state_d = S_PWR;
    endcase

    if (adv) begin
      state_d = S_LOAD;
      if (init_q) begin
        if (idx_q == 4'd11) begin
          init_d     = 1'b0;
          ready_d    = 1'b1;
          row_d      = 1'b0;
          col_d      = '0;
          lo_d       = 1'b0;
          snap_set_d = setTime;
          snap_act_d = activeCh;
          snap_tin_d = timeIn;
          snap_ct_d  = countedTime;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end else if (!lo_q) begin
        lo_d = 1'b1;
      end else begin
        lo_d = 1'b0;
        if (col_q == COLW'(COLS)) begin
          col_d = '0;
          if (row_q == 1'(NUM_CH - 1)) begin
            row_d      = 1'b0;
            fd_d       = 1'b1;
            snap_set_d = setTime;
            snap_act_d = activeCh;
            snap_tin_d = timeIn;
            snap_ct_d  = countedTime;
          end else begin
            row_d = row_q + 1'b1;
          end
        end else begin
          col_d = col_q + COLW'(1);
        end
      end
    end

    lcd_d[5] = (state_d == S_EHIGH);
  end

  // State and output registers; reset drops E immediately and restarts init.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_PWR;
      tmr_q      <= '0;
      gap_q      <= '0;
      init_q     <= 1'b1;
      idx_q      <= '0;
      row_q      <= 1'b0;
      col_q      <= '0;
      lo_q       <= 1'b0;
      snap_set_q <= 1'b0;
      snap_act_q <= 1'b0;
      snap_tin_q <= '0;
      snap_ct_q  <= '0;
      lcd_q      <= '0;
      ready_q    <= 1'b0;
      fd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      gap_q      <= gap_d;
      init_q     <= init_d;
      idx_q      <= idx_d;
      row_q      <= row_d;
      col_q      <= col_d;
      lo_q       <= lo_d;
      snap_set_q <= snap_set_d;
      snap_act_q <= snap_act_d;
      snap_tin_q <= snap_tin_d;
      snap_ct_q  <= snap_ct_d;
      lcd_q      <= lcd_d;
      ready_q    <= ready_d;
      fd_q       <= fd_d;
    end
  end

  assign lcd        = lcd_q;
  assign ready      = ready_q;
  assign frame_done = fd_q;

endmodule
